algo_1rw_scrub: RTL and testbench
=================================

// Module: algo_1rw_scrub
// PURPOSE
//  Sits directly downstream of the 1RW algorithmic memory and consumes its read response
//  (read_vld/dout/read_serr/read_derr/read_padr). Single-error reads are queued and written
//  back with the returned (corrected) data, which clears the error. Double errors are counted
//  and their physical address is latched for software. Scrub writes go to the port arbiter
//  upstream over a req/gnt handshake; host port activity is tapped to match and kill stale entries.
// PARAMETERS
//  BITADDR  4  logical address width
//  WIDTH    4  data width
//  BITPADR  5  physical address width (read_padr)
//  DELAY    1  memory read latency in cycles, read_0 to read_vld_0 (>=1)
//  FIFODEP  4  scrub queue depth (power of 2)
//  BITFIFO  2  log2(FIFODEP)
//  BITCNT   8  width of the statistics counters
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous, active-high reset
//  read_0      in   1        tap: read issued on the memory port this cycle
//  write_0     in   1        tap: write issued on the memory port this cycle (host or scrub)
//  addr_0      in   BITADDR  tap: memory port address
//  read_vld_0  in   1        memory read response valid
//  dout_0      in   WIDTH    memory read data
//  read_serr_0 in   1        single (correctable) error on this response
//  read_derr_0 in   1        double (uncorrectable) error; always set together with serr
//  read_padr_0 in   BITPADR  physical address of the response
//  scrub_req   out  1        scrub write request to the port arbiter
//  scrub_addr  out  BITADDR  scrub write address
//  scrub_din   out  WIDTH    scrub write data
//  scrub_gnt   in   1        arbiter grants scrub_req; write is issued this cycle
//  derr_vld    out  1        sticky: a double error has been latched
//  derr_padr   out  BITPADR  physical address of the first unacknowledged double error
//  derr_clr    in   1        clears derr_vld
//  serr_cnt    out  BITCNT   single errors accepted into the queue, saturating
//  derr_cnt    out  BITCNT   double errors seen, saturating
//  drop_cnt    out  BITCNT   single errors dropped (queue full), saturating
//  busy        out  1        queue non-empty or scrub_req asserted
// BEHAVIOUR
//  Reset: all outputs 0, queue emptied, FSM to IDLE, address pipeline valid bits cleared.
//  Addr pipe: addr_0 is qualified by read_0 and delayed DELAY stages; its output is paired with read_vld_0.
//  Classify on read_vld_0: serr&!derr -> push {addr,dout_0}; derr -> derr_cnt+1;
//   if !derr_vld then latch read_padr_0 and set derr_vld. Once set, derr_padr holds
//   (first error wins). derr_clr clears derr_vld; a new derr in the same cycle re-latches.
//  Push while full (no pop same cycle) -> entry dropped, drop_cnt+1. Push+pop same cycle
//   when full is accepted.
//  Push in the same cycle as write_0 to the same addr -> entry discarded. No counter increments.
//  Kill: write_0 to addr_0 equal to a queued entry's addr clears that entry's valid bit.
//   Exception: the head entry when scrub_gnt is high, since that write is the scrub itself.
//  FSM IDLE: if head present and valid -> REQ next cycle; if head invalid -> pop, stay IDLE.
//  FSM REQ: scrub_req=1, scrub_addr/din = head (registered, stable while req).
//   scrub_gnt -> pop, IDLE; scrub_req drops the next cycle (one write per entry).
//   Head killed without gnt -> pop, IDLE, no write.
//  Minimum spacing between consecutive scrub requests: 1 idle cycle.
//  Counters saturate at all-ones and never wrap.
//  Reset mid-REQ: scrub_req low the next cycle and the entry is lost; bench must tolerate this.
// TESTING
//  1. serr at addr 5, dout 4'hA -> scrub_req in 2 cycles with addr 5 / din A; gnt -> req low
//     next cycle; serr_cnt=1.
//  2. derr at padr 5'h13 then a second derr at padr 5'h02 -> derr_padr=13, derr_cnt=2;
//     derr_clr -> derr_vld=0; no scrub_req.
//  3. 6 serr responses, gnt held low -> 4 queued, drop_cnt=2; release gnt -> 4 writes in FIFO order.
//  4. Queue serr at addr 3, host write_0 to addr 3 before gnt -> entry killed, no scrub_req for 3.
//  5. serr push and scrub gnt/pop in the same cycle at full -> occupancy unchanged, drop_cnt unchanged.
//  6. rst during REQ with 3 queued -> all outputs 0 next cycle; new serr afterwards is scrubbed normally.

Source files
------------

// File: rtl/algo_1rw_scrub.sv
// ---------------------------------------------------------------------------
// algo_1rw_scrub
//
// Error scrubber placed directly behind the read response of a 1RW
// algorithmic memory. Correctable (single-error) reads are queued together
// with their corrected data and written back through the upstream port
// arbiter, which clears the stored error. Uncorrectable (double-error) reads
// are counted, and the physical address of the first one is held for
// software until acknowledged.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   read_0, write_0,    tap of the memory port: read/write issued this cycle
//   addr_0              and its logical address
//   read_vld_0, dout_0  read response valid / corrected read data
//   read_serr_0         single (correctable) error on this response
//   read_derr_0         double (uncorrectable) error, comes with serr
//   read_padr_0         physical address of the response
//   scrub_req/addr/din  scrub write request towards the port arbiter
//   scrub_gnt           arbiter accepts the scrub write this cycle
//   derr_vld, derr_padr sticky double-error flag and its physical address
//   derr_clr            software acknowledge of derr_vld
//   serr_cnt, derr_cnt, saturating statistics: singles queued, doubles
//   drop_cnt            seen, singles dropped on a full queue
//   busy                queue non-empty or a scrub request outstanding
// ---------------------------------------------------------------------------
module algo_1rw_scrub #(
  parameter int BITADDR = 4,
  parameter int WIDTH   = 4,
  parameter int BITPADR = 5,
  parameter int DELAY   = 1,
  parameter int FIFODEP = 4,
  parameter int BITFIFO = 2,
  parameter int BITCNT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_0,
  input  logic               write_0,
  input  logic [BITADDR-1:0] addr_0,
  input  logic               read_vld_0,
  input  logic [WIDTH-1:0]   dout_0,
  input  logic               read_serr_0,
  input  logic               read_derr_0,
  input  logic [BITPADR-1:0] read_padr_0,
  output logic               scrub_req,
  output logic [BITADDR-1:0] scrub_addr,
  output logic [WIDTH-1:0]   scrub_din,
  input  logic               scrub_gnt,
  output logic               derr_vld,
  output logic [BITPADR-1:0] derr_padr,
  input  logic               derr_clr,
  output logic [BITCNT-1:0]  serr_cnt,
  output logic [BITCNT-1:0]  derr_cnt,
  output logic [BITCNT-1:0]  drop_cnt,
  output logic               busy
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state;

  // Read address pipeline, aligned with the memory read latency
  logic [DELAY-1:0]   pipe_vld;
  logic [BITADDR-1:0] pipe_addr [DELAY];

  // Scrub queue: payload array plus per-entry live bit (occupied and not killed)
  logic [BITADDR-1:0] q_addr [FIFODEP];
  logic [WIDTH-1:0]   q_data [FIFODEP];
  logic [FIFODEP-1:0] q_live;
  logic [FIFODEP-1:0] live_nxt;
  logic [FIFODEP-1:0] kill_mask;
  logic [BITFIFO-1:0] wr_ptr;
  logic [BITFIFO-1:0] rd_ptr;
  logic [BITFIFO:0]   q_cnt;

  logic               resp_vld;
  logic [BITADDR-1:0] resp_addr;
  logic               q_empty;
  logic               q_full;
  logic               gnt_now;
  logic               head_hit;
  logic               head_alive;
  logic               pop;
  logic               push_want;
  logic               push;
  logic               drop;
  logic               derr_ev;

  function automatic logic [BITCNT-1:0] sat_inc(input logic [BITCNT-1:0] v);
    return (&v) ? v : v + BITCNT'(1);
  endfunction

  assign resp_vld  = read_vld_0 && pipe_vld[DELAY-1];
  assign resp_addr = pipe_addr[DELAY-1];
  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == (BITFIFO+1)'(FIFODEP));
  assign gnt_now   = (state == REQ) && scrub_gnt;

  // A host write to the head address kills it, unless that write is the
  // granted scrub itself.
  assign head_hit   = write_0 && q_live[rd_ptr] && (q_addr[rd_ptr] == addr_0);
  assign head_alive = q_live[rd_ptr] && !(head_hit && !gnt_now);

  // Pop after a granted scrub, or whenever the head entry is dead.
  assign pop = !q_empty && (gnt_now || !head_alive);

  // A response overtaken by a same-cycle write to its address carries stale
  // data: discard it silently.
  assign push_want = resp_vld && read_serr_0 && !read_derr_0 &&
                     !(write_0 && (addr_0 == resp_addr));
  assign push      = push_want && (!q_full || pop);
  assign drop      = push_want && q_full && !pop;
  assign derr_ev   = resp_vld && read_derr_0;

  assign busy = !q_empty || scrub_req;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < FIFODEP; i++) begin
      kill_mask[i] = write_0 && q_live[i] && (q_addr[i] == addr_0) &&
                     !(gnt_now && (rd_ptr == BITFIFO'(i)));
    end
    live_nxt = q_live & ~kill_mask;
    if (pop)  live_nxt[rd_ptr] = 1'b0;
    if (push) live_nxt[wr_ptr] = 1'b1;
  end

  // NOTE: storage arrays are not reset; the live bits and pipeline valid
  // bits say which slots hold meaningful data, so clearing payloads buys nothing.
  always_ff @(posedge clk) begin
    pipe_addr[0] <= addr_0;
    for (int i = 1; i < DELAY; i++) pipe_addr[i] <= pipe_addr[i-1];
    if (push) begin
      q_addr[wr_ptr] <= resp_addr;
      q_data[wr_ptr] <= dout_0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      q_live   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_cnt    <= '0;
    end else begin
      pipe_vld[0] <= read_0;
      for (int i = 1; i < DELAY; i++) pipe_vld[i] <= pipe_vld[i-1];
      q_live <= live_nxt;
      if (push) wr_ptr <= wr_ptr + BITFIFO'(1);
      if (pop)  rd_ptr <= rd_ptr + BITFIFO'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (BITFIFO+1)'(1);
        2'b01:   q_cnt <= q_cnt - (BITFIFO+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Scrub request FSM. Request fields are registered on entry to REQ and
  // held until the request drops; returning through IDLE guarantees at
  // least one idle cycle between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scrub_req  <= 1'b0;
      scrub_addr <= '0;
      scrub_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!q_empty && head_alive) begin
            state      <= REQ;
            scrub_req  <= 1'b1;
            scrub_addr <= q_addr[rd_ptr];
            scrub_din  <= q_data[rd_ptr];
          end
        end
        REQ: begin
          if (scrub_gnt || !head_alive) begin
            state     <= IDLE;
            scrub_req <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          scrub_req <= 1'b0;
        end
      endcase
    end
  end

  // Double-error capture and statistics. The first unacknowledged error
  // keeps its address; an acknowledge coinciding with a new error re-arms
  // the capture with the new address.
  always_ff @(posedge clk) begin
    if (rst) begin
      derr_vld  <= 1'b0;
      derr_padr <= '0;
      serr_cnt  <= '0;
      derr_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (derr_ev && (!derr_vld || derr_clr)) begin
        derr_vld  <= 1'b1;
        derr_padr <= read_padr_0;
      end else if (derr_clr) begin
        derr_vld <= 1'b0;
      end
      if (derr_ev) derr_cnt <= sat_inc(derr_cnt);
      if (push)    serr_cnt <= sat_inc(serr_cnt);
      if (drop)    drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_algo_1rw_scrub.sv
// ---------------------------------------------------------------------------
// tb_algo_1rw_scrub
//
// Directed bench for algo_1rw_scrub (read latency 1, queue depth 4).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, half a cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_algo_1rw_scrub;

  logic       clk = 1'b0;
  logic       rst;
  logic       read_0, write_0;
  logic [3:0] addr_0;
  logic       read_vld_0;
  logic [3:0] dout_0;
  logic       read_serr_0, read_derr_0;
  logic [4:0] read_padr_0;
  logic       scrub_req;
  logic [3:0] scrub_addr;
  logic [3:0] scrub_din;
  logic       scrub_gnt;
  logic       derr_vld;
  logic [4:0] derr_padr;
  logic       derr_clr;
  logic [7:0] serr_cnt, derr_cnt, drop_cnt;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  algo_1rw_scrub #(
    .BITADDR(4), .WIDTH(4), .BITPADR(5), .DELAY(1),
    .FIFODEP(4), .BITFIFO(2), .BITCNT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .read_0(read_0), .write_0(write_0), .addr_0(addr_0),
    .read_vld_0(read_vld_0), .dout_0(dout_0),
    .read_serr_0(read_serr_0), .read_derr_0(read_derr_0), .read_padr_0(read_padr_0),
    .scrub_req(scrub_req), .scrub_addr(scrub_addr), .scrub_din(scrub_din),
    .scrub_gnt(scrub_gnt),
    .derr_vld(derr_vld), .derr_padr(derr_padr), .derr_clr(derr_clr),
    .serr_cnt(serr_cnt), .derr_cnt(derr_cnt), .drop_cnt(drop_cnt),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Read on the tap, then its response one cycle later. Optional derr_clr
  // and host write in the response cycle. Returns at the next falling edge
  // with all inputs idle.
  task automatic resp(input logic [3:0] a, input logic [3:0] d, input logic se,
                      input logic de, input logic [4:0] pa, input logic clr,
                      input logic wr, input logic [3:0] wa);
    read_0 = 1'b1; addr_0 = a;
    @(negedge clk);
    read_0 = 1'b0; addr_0 = wa; write_0 = wr; derr_clr = clr;
    read_vld_0 = 1'b1; dout_0 = d; read_serr_0 = se; read_derr_0 = de; read_padr_0 = pa;
    @(negedge clk);
    read_vld_0 = 1'b0; read_serr_0 = 1'b0; read_derr_0 = 1'b0; read_padr_0 = '0;
    dout_0 = '0; write_0 = 1'b0; addr_0 = '0; derr_clr = 1'b0;
  endtask

  task automatic serr_resp(input logic [3:0] a, input logic [3:0] d);
    resp(a, d, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic derr_resp(input logic [4:0] pa, input logic clr);
    resp(4'h0, 4'h0, 1'b1, 1'b1, pa, clr, 1'b0, 4'h0);
  endtask

  // Wait (bounded) for a scrub request, check it, grant it for one cycle
  // with the matching write on the tap, and check the request drops.
  task automatic grant(input string tag, input logic [3:0] ea, input logic [3:0] ed);
    for (int k = 0; k < 20 && !scrub_req; k++) @(negedge clk);
    check({tag, "_req"}, scrub_req, 1);
    if (scrub_req) begin
      check({tag, "_addr"}, scrub_addr, ea);
      check({tag, "_din"}, scrub_din, ed);
      scrub_gnt = 1'b1; write_0 = 1'b1; addr_0 = ea;
      @(negedge clk);
      scrub_gnt = 1'b0; write_0 = 1'b0; addr_0 = '0;
      check({tag, "_drop"}, scrub_req, 0);
    end
  endtask

  task automatic expect_no_req(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      seen = seen | scrub_req;
    end
    check(tag, seen, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   scrub_req, 0);
    check({tag, "_saddr"}, scrub_addr, 0);
    check({tag, "_sdin"},  scrub_din, 0);
    check({tag, "_dvld"},  derr_vld, 0);
    check({tag, "_dpadr"}, derr_padr, 0);
    check({tag, "_scnt"},  serr_cnt, 0);
    check({tag, "_dcnt"},  derr_cnt, 0);
    check({tag, "_pcnt"},  drop_cnt, 0);
    check({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; read_0 = 1'b0; write_0 = 1'b0; addr_0 = '0;
    read_vld_0 = 1'b0; dout_0 = '0; read_serr_0 = 1'b0; read_derr_0 = 1'b0;
    read_padr_0 = '0; scrub_gnt = 1'b0; derr_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // 1: single error at addr 5 -> request two cycles after the response
    serr_resp(4'h5, 4'hA);
    check("t1_req_early", scrub_req, 0);
    check("t1_serr_cnt", serr_cnt, 1);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_req_2cyc", scrub_req, 1);
    grant("t1", 4'h5, 4'hA);
    check("t1_idle", busy, 0);

    // 2: double errors, first address wins, clear, clear+new re-latches
    derr_resp(5'h13, 1'b0);
    check("t2_vld", derr_vld, 1);
    check("t2_padr", derr_padr, 5'h13);
    check("t2_cnt1", derr_cnt, 1);
    derr_resp(5'h02, 1'b0);
    check("t2_padr_hold", derr_padr, 5'h13);
    check("t2_cnt2", derr_cnt, 2);
    derr_clr = 1'b1;
    @(negedge clk);
    derr_clr = 1'b0;
    check("t2_clr", derr_vld, 0);
    derr_resp(5'h07, 1'b1);
    check("t2_relatch_vld", derr_vld, 1);
    check("t2_relatch_padr", derr_padr, 5'h07);
    check("t2_cnt3", derr_cnt, 3);
    // back-to-back double errors drive the counter into saturation
    read_0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 260; i++) begin
      read_vld_0 = 1'b1; read_serr_0 = 1'b1; read_derr_0 = 1'b1;
      read_padr_0 = 5'(i + 5);
      @(negedge clk);
    end
    read_0 = 1'b0; read_vld_0 = 1'b0; read_serr_0 = 1'b0; read_derr_0 = 1'b0;
    read_padr_0 = '0;
    @(negedge clk);
    check("t2_sat", derr_cnt, 8'hFF);
    check("t2_padr_first", derr_padr, 5'h07);
    derr_clr = 1'b1;
    @(negedge clk);
    derr_clr = 1'b0;
    check("t2_clr2", derr_vld, 0);
    check("t2_serr_cnt", serr_cnt, 1);
    check("t2_busy", busy, 0);
    expect_no_req("t2_no_req", 4);

    // 3: six singles with grant held low -> four queued, two dropped
    for (int i = 1; i <= 6; i++) serr_resp(4'(i), ~4'(i));
    check("t3_drop", drop_cnt, 2);
    check("t3_serr_cnt", serr_cnt, 5);
    check("t3_busy", busy, 1);
    grant("t3_w1", 4'h1, 4'hE);
    grant("t3_w2", 4'h2, 4'hD);
    grant("t3_w3", 4'h3, 4'hC);
    grant("t3_w4", 4'h4, 4'hB);
    expect_no_req("t3_no_more", 6);
    check("t3_idle", busy, 0);

    // 4: host write kills a queued entry; write in the response cycle discards
    serr_resp(4'h1, 4'h6);
    serr_resp(4'h3, 4'h9);
    write_0 = 1'b1; addr_0 = 4'h3;
    @(negedge clk);
    write_0 = 1'b0; addr_0 = '0;
    grant("t4_w1", 4'h1, 4'h6);
    expect_no_req("t4_killed", 6);
    check("t4_idle", busy, 0);
    check("t4_serr_cnt", serr_cnt, 7);
    resp(4'h9, 4'h2, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 4'h9);
    check("t4_discard_cnt", serr_cnt, 7);
    check("t4_discard_busy", busy, 0);
    expect_no_req("t4_discard_req", 4);
    check("t4_drop", drop_cnt, 2);

    // 5: push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) serr_resp(4'(8 + i), 4'(1 + i));
    check("t5_serr_cnt", serr_cnt, 11);
    check("t5_head", scrub_addr, 4'h8);
    read_0 = 1'b1; addr_0 = 4'hC;
    @(negedge clk);
    read_0 = 1'b0; read_vld_0 = 1'b1; read_serr_0 = 1'b1; dout_0 = 4'h5;
    scrub_gnt = 1'b1; write_0 = 1'b1; addr_0 = 4'h8;
    @(negedge clk);
    read_vld_0 = 1'b0; read_serr_0 = 1'b0; dout_0 = '0;
    scrub_gnt = 1'b0; write_0 = 1'b0; addr_0 = '0;
    check("t5_drop", drop_cnt, 2);
    check("t5_serr_cnt2", serr_cnt, 12);
    check("t5_req_drop", scrub_req, 0);
    grant("t5_w9", 4'h9, 4'h2);
    grant("t5_wA", 4'hA, 4'h3);
    grant("t5_wB", 4'hB, 4'h4);
    grant("t5_wC", 4'hC, 4'h5);
    expect_no_req("t5_no_more", 6);
    check("t5_idle", busy, 0);

    // 6: reset during REQ with three queued, then normal operation
    serr_resp(4'h2, 4'h7);
    serr_resp(4'h4, 4'h8);
    serr_resp(4'h6, 4'h9);
    check("t6_req", scrub_req, 1);
    check("t6_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("t6_rst");
    expect_no_req("t6_empty", 4);
    serr_resp(4'h7, 4'h5);
    grant("t6_w7", 4'h7, 4'h5);
    check("t6_serr_cnt", serr_cnt, 1);
    check("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
